addmop_acc_seq: RTL and testbench

- Streaming multi-operand accumulation controller.
- Accepts a frame of unsigned operands, one per handshake beat, and folds each into a carry-save accumulator (S/C register pair) through a 3-operand carry-save compressor slice (depth 3, speed passed through).
- At frame end it resolves S+C with one carry-propagate addition and presents the sum on an output handshake.
- Sits between an operand producer (e.g. a partial-product or dot-product front end) and any consumer of full-width sums.

---
 rtl/addmop_acc_seq.sv | 110 +++++++++++
 tb/tb_addmop_acc_seq.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/addmop_acc_seq.sv
// addmop_acc_seq: streaming carry-save accumulator that resolves one sum per operand frame.
// Define ADDMOP_ACC_SIGNED_EN to accept two's-complement operands (sign extension); default is unsigned.
module addmop_acc_seq #(
    parameter int width    = 8,
    parameter int accWidth = 16,
    parameter int cntWidth = 8,
    parameter int speed    = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CLR,
    input  logic [width-1:0]    A,
    input  logic                A_valid,
    input  logic                A_last,
    output logic                A_ready,
    output logic [accWidth-1:0] Z,
    output logic [cntWidth-1:0] Z_cnt,
    output logic                Z_ovf,
    output logic                Z_valid,
    input  logic                Z_ready
);
    typedef enum logic [1:0] {ACC, FIN, OUT} state_e;
    localparam int unsigned OVF_LIM = 1 << (accWidth - width);

    state_e                state_q, state_d;
    logic [accWidth-1:0]   sr_q, sr_d, cr_q, cr_d, z_q, z_d, ext;
    logic [cntWidth-1:0]   cnt_q, cnt_d, zc_q, zc_d;
    logic                  ovf_q, ovf_d, accept;
    logic [accWidth-1:0]   s_new;
    logic [accWidth-2:0]   c_new;

`ifdef ADDMOP_ACC_SIGNED_EN
    assign ext = {{(accWidth-width){A[width-1]}}, A};
`else
    assign ext = {{(accWidth-width){1'b0}}, A};
`endif

    // Carry is only formed for the low accWidth-1 bits: the top carry would shift out anyway.
    assign s_new = sr_q ^ cr_q ^ ext;
    generate
        if (speed != 0) begin : g_fast
            assign c_new = (sr_q[accWidth-2:0] & cr_q[accWidth-2:0]) | (sr_q[accWidth-2:0] & ext[accWidth-2:0])
                         | (cr_q[accWidth-2:0] & ext[accWidth-2:0]);
        end else begin : g_slow
            assign c_new = (sr_q[accWidth-2:0] & cr_q[accWidth-2:0])
                         | (ext[accWidth-2:0] & (sr_q[accWidth-2:0] ^ cr_q[accWidth-2:0]));
        end
    endgenerate

    assign accept = A_valid && state_q == ACC && !CLR;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ACC;
            sr_q    <= '0;
            cr_q    <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
            zc_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cr_q    <= cr_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            zc_q    <= zc_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (CLR)
            state_d = ACC;
        else if (state_q == ACC)
            state_d = (A_valid && A_last) ? FIN : ACC;
        else if (state_q == FIN)
            state_d = OUT;
        else if (state_q == OUT)
            state_d = Z_ready ? ACC : OUT;
    end

    always_comb begin
        sr_d  = accept ? s_new : sr_q;
        cr_d  = accept ? {c_new, 1'b0} : cr_q;
        cnt_d = accept ? ((&cnt_q) ? cnt_q : cnt_q + 1'b1) : cnt_q;
        z_d   = z_q;
        zc_d  = zc_q;
        ovf_d = ovf_q;
        if (CLR || state_q == FIN) begin
            sr_d  = '0;
            cr_d  = '0;
            cnt_d = '0;
        end
        if (!CLR && state_q == FIN) begin
            z_d   = sr_q + cr_q;
            zc_d  = cnt_q;
            ovf_d = 32'(cnt_q) > OVF_LIM;
        end
    end

    always_comb begin
        A_ready = state_q == ACC;
        Z_valid = state_q == OUT;
        Z       = z_q;
        Z_cnt   = zc_q;
        Z_ovf   = ovf_q;
    end
endmodule

// File: tb/tb_addmop_acc_seq.sv
// tb_addmop_acc_seq: directed checks of frame sums, latency, stall, clear and async reset.
module tb_addmop_acc_seq;
    logic        CLK = 1'b0, RST = 1'b1, CLR = 1'b0;
    logic [7:0]  A = '0;
    logic        A_valid = 1'b0, A_last = 1'b0, A_ready;
    logic [11:0] Z;
    logic [7:0]  Z_cnt;
    logic        Z_ovf, Z_valid, Z_ready = 1'b0;
    int          errors = 0, checks = 0;

    addmop_acc_seq #(.width(8), .accWidth(12), .cntWidth(8)) dut (
        .CLK(CLK), .RST(RST), .CLR(CLR), .A(A), .A_valid(A_valid), .A_last(A_last),
        .A_ready(A_ready), .Z(Z), .Z_cnt(Z_cnt), .Z_ovf(Z_ovf), .Z_valid(Z_valid), .Z_ready(Z_ready)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic last);
        A = a;
        A_valid = 1'b1;
        A_last = last;
        @(negedge CLK);
        A_valid = 1'b0;
        A_last = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        chk("rst_Z", 32'(Z), 0);
        chk("rst_cnt", 32'(Z_cnt), 0);
        chk("rst_ovf", 32'(Z_ovf), 0);
        chk("rst_valid", 32'(Z_valid), 0);
        chk("rst_ready", 32'(A_ready), 1);
        RST = 1'b0;
        // frame 3,5,250: valid two edges after the last beat, held one cycle
        Z_ready = 1'b1;
        send(8'd3, 1'b0);
        send(8'd5, 1'b0);
        send(8'd250, 1'b1);
        chk("f1_fin_valid", 32'(Z_valid), 0);
        chk("f1_fin_ready", 32'(A_ready), 0);
        @(negedge CLK);
        chk("f1_valid", 32'(Z_valid), 1);
        chk("f1_Z", 32'(Z), 258);
        chk("f1_cnt", 32'(Z_cnt), 3);
        chk("f1_ovf", 32'(Z_ovf), 0);
        @(negedge CLK);
        chk("f1_done_valid", 32'(Z_valid), 0);
        chk("f1_done_ready", 32'(A_ready), 1);
        chk("f1_Z_kept", 32'(Z), 258);
        // single beat with consumer stall
        Z_ready = 1'b0;
        send(8'hFF, 1'b1);
        @(negedge CLK);
        chk("f2_Z", 32'(Z), 255);
        chk("f2_cnt", 32'(Z_cnt), 1);
        for (int i = 0; i < 5; i++) begin
            chk("f2_stall_Z", 32'(Z), 255);
            chk("f2_stall_valid", 32'(Z_valid), 1);
            chk("f2_stall_ready", 32'(A_ready), 0);
            @(negedge CLK);
        end
        Z_ready = 1'b1;
        @(negedge CLK);
        chk("f2_release_ready", 32'(A_ready), 1);
        chk("f2_release_valid", 32'(Z_valid), 0);
        // overflow bound: 17 beats flag, 16 beats do not
        for (int i = 0; i < 17; i++) send(8'hFF, i == 16);
        @(negedge CLK);
        chk("f17_Z", 32'(Z), 239);
        chk("f17_cnt", 32'(Z_cnt), 17);
        chk("f17_ovf", 32'(Z_ovf), 1);
        @(negedge CLK);
        for (int i = 0; i < 16; i++) send(8'hFF, i == 15);
        @(negedge CLK);
        chk("f16_Z", 32'(Z), 4080);
        chk("f16_cnt", 32'(Z_cnt), 16);
        chk("f16_ovf", 32'(Z_ovf), 0);
        @(negedge CLK);
        // gapped beats then CLR with a colliding last beat that must be dropped
        send(8'd10, 1'b0);
        repeat (2) @(negedge CLK);
        send(8'd20, 1'b0);
        @(negedge CLK);
        CLR = 1'b1;
        A = 8'd99;
        A_valid = 1'b1;
        A_last = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        A_valid = 1'b0;
        A_last = 1'b0;
        chk("clr_ready", 32'(A_ready), 1);
        chk("clr_valid", 32'(Z_valid), 0);
        chk("clr_Z_kept", 32'(Z), 4080);
        send(8'd7, 1'b1);
        @(negedge CLK);
        chk("clr_Z", 32'(Z), 7);
        chk("clr_cnt", 32'(Z_cnt), 1);
        @(negedge CLK);
        // asynchronous reset while presenting a result
        Z_ready = 1'b0;
        send(8'd3, 1'b0);
        send(8'd5, 1'b0);
        send(8'd250, 1'b1);
        @(negedge CLK);
        chk("ar_pre_Z", 32'(Z), 258);
        #2 RST = 1'b1;
        #1;
        chk("ar_Z", 32'(Z), 0);
        chk("ar_valid", 32'(Z_valid), 0);
        chk("ar_ready", 32'(A_ready), 1);
        @(negedge CLK);
        RST = 1'b0;
        Z_ready = 1'b1;
        send(8'd1, 1'b0);
        send(8'd1, 1'b1);
        @(negedge CLK);
        chk("ar_next_Z", 32'(Z), 2);
        chk("ar_next_cnt", 32'(Z_cnt), 2);
        @(negedge CLK);
        // 0xFF, 0x02, 0x80: -127 when signed, 385 when unsigned
        send(8'hFF, 1'b0);
        send(8'h02, 1'b0);
        send(8'h80, 1'b1);
        @(negedge CLK);
`ifdef ADDMOP_ACC_SIGNED_EN
        chk("mix_Z", 32'(Z), 32'hF81);
`else
        chk("mix_Z", 32'(Z), 385);
`endif
        chk("mix_cnt", 32'(Z_cnt), 3);
        chk("mix_ovf", 32'(Z_ovf), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
